// File: rtl/say_initiator.sv
// Caller side of the one-argument "say" action: FIFO-buffers producer values and issues
// them to a responder, with a post-call idle gap and a sticky stall timeout flag.
module say_initiator #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     enq__ENA,
  input  logic [31:0]              enq_v,
  output logic                     enq__RDY,
  output logic                     say__ENA,
  output logic [31:0]              say_va,
  input  logic                     say__RDY,
  output logic [31:0]              issued,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     timeout_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  logic [31:0]    mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic [GW-1:0]  gap_cnt;
  logic [SW-1:0]  stall_cnt;

  logic armed;
  logic push;
  logic fire;
  logic stalled;

  // ARMED: something queued and the post-call gap has elapsed
  assign armed    = (count != CW'(0)) && (gap_cnt == GW'(0));
  assign enq__RDY = (count != CW'(DEPTH));
  assign push     = enq__ENA && enq__RDY;
  assign fire     = armed && say__RDY;
  assign stalled  = armed && !say__RDY;

  assign say__ENA  = fire;
  assign say_va    = mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      gap_cnt     <= '0;
      stall_cnt   <= '0;
      issued      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (fire) rd_ptr <= rd_ptr + PW'(1);

      if (push && !fire)      count <= count + CW'(1);
      else if (fire && !push) count <= count - CW'(1);

      if (fire)                   gap_cnt <= GW'(GAP);
      else if (gap_cnt != GW'(0)) gap_cnt <= gap_cnt - GW'(1);

      // stall counter saturates; the flag latches on the cycle it reaches TIMEOUT
      if (fire || count == CW'(0))                stall_cnt <= '0;
      else if (stalled && stall_cnt != SW'(TIMEOUT)) stall_cnt <= stall_cnt + SW'(1);

      if (stalled && stall_cnt >= SW'(TIMEOUT - 1)) timeout_err <= 1'b1;

      if (fire) issued <= issued + 32'd1;
    end
  end

  // storage needs no reset: pointers and count define validity
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= enq_v;
  end

endmodule

// File: tb/tb_say_initiator.sv
// Randomized scoreboard bench for say_initiator against a queue-based reference model.
module tb_say_initiator;

  localparam int DEPTH   = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        enq_ena = 1'b0;
  logic [31:0] enq_v = '0;
  logic        say_rdy = 1'b0;
  logic        enq_rdy;
  logic        say_ena;
  logic [31:0] say_va;
  logic [31:0] issued;
  logic [2:0]  occupancy;
  logic        timeout_err;

  say_initiator #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .CLK         (clk),
    .nRST        (nrst),
    .enq__ENA    (enq_ena),
    .enq_v       (enq_v),
    .enq__RDY    (enq_rdy),
    .say__ENA    (say_ena),
    .say_va      (say_va),
    .say__RDY    (say_rdy),
    .issued      (issued),
    .occupancy   (occupancy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  bit          chk_en  = 1'b0;

  // reference model: value queue for the scoreboard plus abstract counters
  logic [31:0] sb[$];
  int          m_cnt   = 0;
  int          m_gap   = 0;
  int          m_stall = 0;
  bit          m_terr  = 1'b0;
  logic [31:0] m_iss   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // monitor + model step, mid-cycle while inputs are stable
  always @(negedge clk) begin
    bit armed;
    bit exp_fire;
    bit accept;
    armed    = (m_cnt > 0) && (m_gap == 0);
    exp_fire = armed && say_rdy;
    accept   = enq_ena && (m_cnt != DEPTH);

    if (chk_en) begin
      check("enq_rdy",     32'(enq_rdy),     32'(m_cnt != DEPTH));
      check("occupancy",   32'(occupancy),   32'(m_cnt));
      check("issued",      issued,           m_iss);
      check("timeout_err", 32'(timeout_err), 32'(m_terr));
      check("say_ena",     32'(say_ena),     32'(exp_fire));
      if (say_ena === 1'b1) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL say_va: call 0x%08h issued with nothing queued at %0t", say_va, $time);
        end else begin
          check("say_va", say_va, sb.pop_front());
        end
      end
    end

    if (!nrst) begin
      sb.delete();
      m_cnt   = 0;
      m_gap   = 0;
      m_stall = 0;
      m_terr  = 1'b0;
      m_iss   = '0;
      chk_en  = 1'b1;
    end else begin
      if (exp_fire || m_cnt == 0) m_stall = 0;
      else if (armed && !say_rdy) begin
        if (m_stall < TIMEOUT) m_stall++;
        if (m_stall == TIMEOUT) m_terr = 1'b1;
      end
      if (exp_fire) m_gap = GAP;
      else if (m_gap > 0) m_gap--;
      if (exp_fire) begin
        m_cnt--;
        m_iss++;
      end
      if (accept) begin
        m_cnt++;
        sb.push_back(enq_v);
      end
    end
  end

  task automatic step(input bit rst_n, input bit en, input logic [31:0] v, input bit rdy);
    nrst    = rst_n;
    enq_ena = en;
    enq_v   = v;
    say_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    int pe;
    int pr;
    int len;

    // reset held with a push request pending
    step(1'b0, 1'b1, 32'hDEAD_0001, 1'b1);
    step(1'b0, 1'b1, 32'hDEAD_0002, 1'b1);

    // single value, latency 1
    step(1'b1, 1'b1, 32'h11, 1'b1);
    idle(4, 1'b1);

    // back-to-back pushes spaced out by the gap
    step(1'b1, 1'b1, 32'hA, 1'b1);
    step(1'b1, 1'b1, 32'hB, 1'b1);
    step(1'b1, 1'b1, 32'hC, 1'b1);
    idle(10, 1'b1);

    // fill while responder busy, fifth push dropped
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h40 + 32'(i), 1'b0);
    idle(16, 1'b1);

    // timeout with one queued value, then recovery
    step(1'b1, 1'b1, 32'h55, 1'b0);
    idle(18, 1'b0);
    idle(4, 1'b1);

    // full fifo: push alongside a pop is refused, next cycle accepted
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h60 + 32'(i), 1'b0);
    step(1'b1, 1'b1, 32'h66, 1'b1);
    step(1'b1, 1'b1, 32'h67, 1'b0);
    idle(20, 1'b1);

    // randomized segments with varied push/ready bias and sporadic resets
    for (int s = 0; s < 40; s++) begin
      if (s % 5 == 0) begin
        step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      end
      pe  = $urandom_range(0, 100);
      pr  = (s % 5 == 4) ? 0 : $urandom_range(0, 100);
      len = $urandom_range(20, 60);
      for (int c = 0; c < len; c++) begin
        step(1'($urandom_range(0, 199) != 0),
             1'($urandom_range(0, 99) < pe),
             $urandom,
             1'($urandom_range(0, 99) < pr));
      end
    end

    idle(24, 1'b1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
